alu_bcd_converter: RTL and testbench
====================================

// Module: alu_bcd_converter
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//  Sits directly downstream of the registered ALU and consumes its 8-bit result.
//  Produces decimal digits for the seven-segment decoders, so the ALU result
//  can be shown as 0..255 instead of hex.
//  A start/busy/done handshake lets the top level convert the result after
//  each ALU clock.
// PARAMETERS
//  WIDTH   8  binary input width in bits.
//  DIGITS  3  number of BCD output digits.
//             Constraint: 10**DIGITS > 2**WIDTH-1, so the output never overflows.
// PORTS
//  clock     in   1           Single clock; all state updates on its rising edge.
//  reset_n   in   1           Asynchronous active-low reset.
//  start     in   1           Request a conversion of bin_in. Level, sampled on posedge.
//  bin_in    in   WIDTH       Unsigned binary value to convert (ALU Out).
//  busy      out  1           High while a conversion is in progress.
//  done      out  1           One-cycle pulse: bcd_out has just been updated.
//  bcd_out   out  4*DIGITS    Packed BCD. Digit 0 (units) in [3:0], hundreds in [11:8].
// BEHAVIOUR
//  Reset (async, reset_n=0): takes effect immediately, independent of clock.
//   - Outputs: busy=0, done=0, bcd_out=0.
//   - Internal: state=IDLE, bit counter=0, shift and scratch registers=0.
//  FSM states:
//   - IDLE:  busy=0. If start=1 at posedge:
//            - capture bin_in into the shift register;
//            - clear the BCD scratch register and the counter;
//            - go to SHIFT.
//            If start=0, stay in IDLE.
//   - SHIFT: busy=1. Each posedge does one step, then increments the counter:
//            - for every scratch digit >= 5, add 3 to that digit;
//            - then shift {scratch, shift reg} left by one bit.
//            On the WIDTH-th step:
//            - bcd_out <= final scratch value;
//            - done <= 1;
//            - go to IDLE.
//  Timing:
//   - start sampled at edge E0; steps on edges E1..E(WIDTH).
//   - busy=1 from after E0 to after E(WIDTH).
//   - done=1 only in the cycle after E(WIDTH); bcd_out is valid from that same cycle.
//   - Latency (start to done) is WIDTH+1 edges.
//   - With start held high, a new conversion begins at E(WIDTH+1): one result every WIDTH+1 cycles.
//  Boundary rules:
//   - start while busy: ignored; the in-flight conversion completes unchanged.
//   - bin_in changes during SHIFT: no effect (value is captured at start).
//   - bcd_out holds the previous result during a conversion; it changes only together with done.
//   - done is never high for 2 consecutive cycles.
//   - Reset mid-SHIFT: conversion is aborted, no done pulse, bcd_out=0.
//   - Digit correction uses exactly 4-bit digits; no digit ever exceeds 9 at done.
// TESTING
//  1. bin_in=8'd255, start pulse -> busy for 8 cycles, then done=1 for 1 cycle,
//     bcd_out=12'h255.
//  2. bin_in=0 -> bcd_out=12'h000 with done. Then bin_in=8'd99 -> 12'h099.
//     Then bin_in=8'd200 -> 12'h200 (hundreds carry).
//  3. Start 8'd37, then pulse start with bin_in=8'd250 at step 3, keeping bin_in=250
//     -> single done, bcd_out=12'h037, second start ignored.
//  4. Hold start=1 with bin_in=8'd128 for 30 cycles -> done pulses every 9 cycles,
//     each with bcd_out=12'h128, busy low only in the restart cycle.
//  5. Convert 8'd255 (bcd_out=12'h255), then start 8'd10 and drop reset_n at step 4
//     (between edges) -> busy, done and bcd_out go to 0 immediately, no done pulse.
//     After release, start 8'd10 -> 12'h010.
//  6. Sweep bin_in 0..255 -> each bcd_out decodes to the input value.

Source files
------------

// File: rtl/alu_bcd_converter_if.sv
// Handshake and data bundle between the ALU result register and the BCD converter.
// The master drives start/bin_in; the converter (slave) returns busy/done/bcd_out.
interface alu_bcd_converter_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out
    );
endinterface

// File: rtl/alu_bcd_converter.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// Converts the registered ALU result into packed decimal digits for the display.
module alu_bcd_converter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    alu_bcd_converter_if.slave   bus
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned CAT_W = BCD_W + WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    shift_q, shift_d;
    logic [BCD_W-1:0]    scratch_q, scratch_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [BCD_W-1:0]    adj_c;
    logic [CAT_W-1:0]    cat_c;

    // Add-3 correction: any digit >= 5 would exceed 9 after the upcoming doubling.
    always_comb begin
        adj_c = scratch_q;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (scratch_q[4*d +: 4] >= 4'd5) begin
                adj_c[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
            end
        end
        cat_c = {adj_c, shift_q} << 1;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    shift_d   = bus.bin_in;
                    scratch_d = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = cat_c[CAT_W-1 -: BCD_W];
                shift_d   = cat_c[WIDTH-1:0];
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    bcd_d   = cat_c[CAT_W-1 -: BCD_W];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_alu_bcd_converter.sv
// Directed bench for alu_bcd_converter: vector table, handshake corner cases and full sweep.
module tb_alu_bcd_converter;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DIGITS = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    alu_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [11:0] prev_bcd = 12'h000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'((v / 100) % 10);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    // One full conversion: start pulse, latency/busy/hold checks, result, done width.
    task automatic do_conv(input logic [7:0] bin, input logic [11:0] exp, input string name);
        int  lat;
        int  busy_cnt;
        bit  seen;
        bit  hold_ok;
        @(negedge clk);
        bus.bin_in = bin;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        busy_cnt = bus.busy ? 1 : 0;
        hold_ok  = (bus.bcd_out === prev_bcd) && !bus.done;
        lat  = 0;
        seen = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat  = i;
                seen = 1;
                break;
            end
            if (bus.busy) busy_cnt++;
            if (bus.bcd_out !== prev_bcd) hold_ok = 0;
        end
        chk({name, " done_seen"}, 32'(seen), 32'd1);
        chk({name, " latency"}, 32'(lat), 32'(WIDTH));
        chk({name, " busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
        chk({name, " bcd_hold"}, 32'(hold_ok), 32'd1);
        chk({name, " bcd_out"}, 32'(bus.bcd_out), 32'(exp));
        @(negedge clk);
        chk({name, " done_one_cycle"}, 32'(bus.done), 32'd0);
        prev_bcd = exp;
    endtask

    initial begin
        vec_t vecs[10];
        int   pulses;
        int   last_done;
        int   extra_done;
        bit   seen;
        vecs[0] = '{8'd255, 12'h255};
        vecs[1] = '{8'd0,   12'h000};
        vecs[2] = '{8'd99,  12'h099};
        vecs[3] = '{8'd200, 12'h200};
        vecs[4] = '{8'd1,   12'h001};
        vecs[5] = '{8'd9,   12'h009};
        vecs[6] = '{8'd10,  12'h010};
        vecs[7] = '{8'd100, 12'h100};
        vecs[8] = '{8'd128, 12'h128};
        vecs[9] = '{8'd37,  12'h037};

        bus.start  = 1'b0;
        bus.bin_in = 8'd0;
        #12;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset bcd_out", 32'(bus.bcd_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) begin
            do_conv(vecs[k].bin, vecs[k].bcd, $sformatf("vec%0d", k));
        end

        // Second start arrives mid-conversion and must be ignored.
        @(negedge clk);
        bus.bin_in = 8'd37;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        last_done = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 3) begin
                bus.bin_in = 8'd250;
                bus.start  = 1'b1;
            end else if (i == 4) begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                seen = 1;
                last_done = i;
                break;
            end
        end
        chk("busy_start done_seen", 32'(seen), 32'd1);
        chk("busy_start latency", 32'(last_done), 32'd8);
        chk("busy_start bcd_out", 32'(bus.bcd_out), 32'h037);
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) extra_done++;
        end
        chk("busy_start extra_done", 32'(extra_done), 32'd0);
        chk("busy_start bcd_kept", 32'(bus.bcd_out), 32'h037);
        prev_bcd = 12'h037;

        // Start held high: back-to-back conversions every WIDTH+1 cycles.
        @(negedge clk);
        bus.bin_in = 8'd128;
        bus.start  = 1'b1;
        pulses = 0;
        last_done = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            chk($sformatf("held busy_vs_done c%0d", i), 32'(bus.busy), 32'(!bus.done));
            if (bus.done) begin
                pulses++;
                chk("held bcd_out", 32'(bus.bcd_out), 32'h128);
                if (last_done > 0) chk("held period", 32'(i - last_done), 32'd9);
                last_done = i;
            end
        end
        chk("held pulses", 32'(pulses), 32'd3);
        bus.start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1;
                break;
            end
        end
        chk("held drain done", 32'(seen), 32'd1);
        prev_bcd = 12'h128;

        // Reset in the middle of a conversion.
        do_conv(8'd255, 12'h255, "pre_reset");
        @(negedge clk);
        bus.bin_in = 8'd10;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset busy", 32'(bus.busy), 32'd0);
        chk("mid_reset done", 32'(bus.done), 32'd0);
        chk("mid_reset bcd_out", 32'(bus.bcd_out), 32'd0);
        extra_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) extra_done++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.done) extra_done++;
        end
        chk("mid_reset no_done", 32'(extra_done), 32'd0);
        chk("mid_reset bcd_zero", 32'(bus.bcd_out), 32'd0);
        prev_bcd = 12'h000;
        do_conv(8'd10, 12'h010, "post_reset");

        // Full input sweep against the decimal model.
        for (int v = 0; v < 256; v++) begin
            do_conv(8'(v), to_bcd(v), $sformatf("sweep%0d", v));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
